// File: rtl/flow_rank_store.sv
// Per-flow circular FIFOs of (rank, value) entries with one push port and one pop port.
// Same-flow push+pop on an empty flow bypasses storage; errors are sticky until reset.
module flow_rank_store #(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned FLOWS   = 8,
    parameter int unsigned RANK_W  = 32,
    parameter int unsigned VALUE_W = 32
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 push_valid,
    input  logic [$clog2(FLOWS)-1:0]             push_flow,
    input  logic [RANK_W-1:0]                    push_rank,
    input  logic [VALUE_W-1:0]                   push_value,
    output logic                                 push_ready,
    input  logic                                 pop,
    input  logic [$clog2(FLOWS)-1:0]             pop_flow,
    output logic                                 pop_valid,
    output logic [RANK_W-1:0]                    pop_rank,
    output logic [VALUE_W-1:0]                   pop_value,
    output logic [FLOWS-1:0]                     head_valid,
    output logic [FLOWS*RANK_W-1:0]              head_rank,
    output logic [FLOWS*$clog2(DEPTH+1)-1:0]     count,
    output logic                                 err_overflow,
    output logic                                 err_underflow
);

    localparam int unsigned FLOW_W = $clog2(FLOWS);
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W  = $clog2(DEPTH);

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    ptr_t                head_q [FLOWS];
    ptr_t                head_d [FLOWS];
    ptr_t                tail_q [FLOWS];
    ptr_t                tail_d [FLOWS];
    cnt_t                cnt_q  [FLOWS];
    cnt_t                cnt_d  [FLOWS];
    logic [RANK_W-1:0]   rank_mem_q  [FLOWS][DEPTH];
    logic [VALUE_W-1:0]  value_mem_q [FLOWS][DEPTH];

    logic [FLOWS-1:0]    push_hit_c;
    logic [FLOWS-1:0]    pop_hit_c;
    logic [FLOWS-1:0]    we_c;
    logic                push_acc_c;
    logic                pop_acc_c;
    logic                push_in_range_c;
    logic                pop_in_range_c;

    logic                pop_valid_q, pop_valid_d;
    logic [RANK_W-1:0]   pop_rank_q,  pop_rank_d;
    logic [VALUE_W-1:0]  pop_value_q, pop_value_d;
    logic                err_ovf_q,   err_ovf_d;
    logic                err_unf_q,   err_unf_d;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (32'(p) == DEPTH - 1) ? '0 : p + PTR_W'(1);
    endfunction

    // Acceptance: out-of-range flow numbers never match a flow, so they are never accepted.
    always_comb begin
        push_ready      = 1'b0;
        pop_acc_c       = 1'b0;
        push_in_range_c = 1'b0;
        pop_in_range_c  = 1'b0;
        for (int f = 0; f < FLOWS; f++) begin
            if (push_flow == FLOW_W'(f)) begin
                push_in_range_c = 1'b1;
                if (cnt_q[f] < CNT_W'(DEPTH) || (pop && pop_flow == push_flow)) begin
                    push_ready = 1'b1;
                end
            end
        end
        push_acc_c = push_valid && push_ready;
        for (int f = 0; f < FLOWS; f++) begin
            if (pop_flow == FLOW_W'(f)) begin
                pop_in_range_c = 1'b1;
                if (cnt_q[f] != '0 || (push_acc_c && push_flow == pop_flow)) begin
                    pop_acc_c = pop;
                end
            end
        end
    end

    // Per-flow pointer/count update and pop output selection.
    always_comb begin
        pop_valid_d = pop_acc_c;
        pop_rank_d  = pop_rank_q;
        pop_value_d = pop_value_q;
        err_ovf_d   = err_ovf_q | (push_valid & ~push_ready & push_in_range_c);
        err_unf_d   = err_unf_q | (pop & ~pop_acc_c & pop_in_range_c);
        for (int f = 0; f < FLOWS; f++) begin
            push_hit_c[f] = push_acc_c && (push_flow == FLOW_W'(f));
            pop_hit_c[f]  = pop_acc_c && (pop_flow == FLOW_W'(f));
            head_d[f]     = head_q[f];
            tail_d[f]     = tail_q[f];
            cnt_d[f]      = cnt_q[f];
            we_c[f]       = 1'b0;
            if (!(push_hit_c[f] && pop_hit_c[f] && cnt_q[f] == '0)) begin
                if (push_hit_c[f]) begin
                    we_c[f]   = 1'b1;
                    tail_d[f] = ptr_inc(tail_q[f]);
                end
                if (pop_hit_c[f]) begin
                    head_d[f] = ptr_inc(head_q[f]);
                end
                if (push_hit_c[f] && !pop_hit_c[f]) begin
                    cnt_d[f] = cnt_q[f] + CNT_W'(1);
                end else if (pop_hit_c[f] && !push_hit_c[f]) begin
                    cnt_d[f] = cnt_q[f] - CNT_W'(1);
                end
            end
            if (pop_hit_c[f]) begin
                if (cnt_q[f] == '0) begin
                    pop_rank_d  = push_rank;
                    pop_value_d = push_value;
                end else begin
                    pop_rank_d  = rank_mem_q[f][head_q[f]];
                    pop_value_d = value_mem_q[f][head_q[f]];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int f = 0; f < FLOWS; f++) begin
            if (rst_n && we_c[f]) begin
                rank_mem_q[f][tail_q[f]]  <= push_rank;
                value_mem_q[f][tail_q[f]] <= push_value;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int f = 0; f < FLOWS; f++) begin
                head_q[f] <= '0;
                tail_q[f] <= '0;
                cnt_q[f]  <= '0;
            end
            pop_valid_q <= 1'b0;
            pop_rank_q  <= '0;
            pop_value_q <= '0;
            err_ovf_q   <= 1'b0;
            err_unf_q   <= 1'b0;
        end else begin
            for (int f = 0; f < FLOWS; f++) begin
                head_q[f] <= head_d[f];
                tail_q[f] <= tail_d[f];
                cnt_q[f]  <= cnt_d[f];
            end
            pop_valid_q <= pop_valid_d;
            pop_rank_q  <= pop_rank_d;
            pop_value_q <= pop_value_d;
            err_ovf_q   <= err_ovf_d;
            err_unf_q   <= err_unf_d;
        end
    end

    always_comb begin
        head_valid = '0;
        head_rank  = '0;
        count      = '0;
        for (int f = 0; f < FLOWS; f++) begin
            head_valid[f]                  = (cnt_q[f] != '0);
            head_rank[f*RANK_W +: RANK_W]  = rank_mem_q[f][head_q[f]];
            count[f*CNT_W +: CNT_W]        = cnt_q[f];
        end
    end

    assign pop_valid     = pop_valid_q;
    assign pop_rank      = pop_rank_q;
    assign pop_value     = pop_value_q;
    assign err_overflow  = err_ovf_q;
    assign err_underflow = err_unf_q;

endmodule

// File: tb/tb_flow_rank_store.sv
// Randomized and directed bench for flow_rank_store against an ordered-list model per flow.
module tb_flow_rank_store;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned FLOWS = 3;
    localparam int unsigned CNT_W = 3;

    logic        clk;
    logic        rst_n;
    logic        push_valid;
    logic [1:0]  push_flow;
    logic [7:0]  push_rank;
    logic [7:0]  push_value;
    logic        push_ready;
    logic        pop;
    logic [1:0]  pop_flow;
    logic        pop_valid;
    logic [7:0]  pop_rank;
    logic [7:0]  pop_value;
    logic [2:0]  head_valid;
    logic [23:0] head_rank;
    logic [8:0]  count;
    logic        err_overflow;
    logic        err_underflow;

    flow_rank_store #(
        .DEPTH  (DEPTH),
        .FLOWS  (FLOWS),
        .RANK_W (8),
        .VALUE_W(8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_valid   (push_valid),
        .push_flow    (push_flow),
        .push_rank    (push_rank),
        .push_value   (push_value),
        .push_ready   (push_ready),
        .pop          (pop),
        .pop_flow     (pop_flow),
        .pop_valid    (pop_valid),
        .pop_rank     (pop_rank),
        .pop_value    (pop_value),
        .head_valid   (head_valid),
        .head_rank    (head_rank),
        .count        (count),
        .err_overflow (err_overflow),
        .err_underflow(err_underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: each flow is an ordered list, oldest entry at index 0 ({rank, value}).
    logic [15:0] mlist [3][6];
    int          mcnt  [3];
    bit          m_valid, m_ovf, m_unf;
    logic [7:0]  m_rank, m_val;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic model_clear();
        for (int f = 0; f < 3; f++) mcnt[f] = 0;
        m_valid = 0; m_ovf = 0; m_unf = 0; m_rank = '0; m_val = '0;
    endtask

    task automatic check_outputs();
        check("pop_valid", 32'(pop_valid), 32'(m_valid));
        check("pop_rank", 32'(pop_rank), 32'(m_rank));
        check("pop_value", 32'(pop_value), 32'(m_val));
        check("err_overflow", 32'(err_overflow), 32'(m_ovf));
        check("err_underflow", 32'(err_underflow), 32'(m_unf));
        for (int f = 0; f < 3; f++) begin
            check($sformatf("count[%0d]", f), 32'(count[f*CNT_W +: CNT_W]), 32'(mcnt[f]));
            check($sformatf("head_valid[%0d]", f), 32'(head_valid[f]), 32'(mcnt[f] != 0));
            if (mcnt[f] != 0) begin
                check($sformatf("head_rank[%0d]", f), 32'(head_rank[f*8 +: 8]), 32'(mlist[f][0][15:8]));
            end
        end
    endtask

    // One clock of traffic: check push_ready before the edge, state after it.
    task automatic step(input bit pv, input int pf, input logic [7:0] pr, input logic [7:0] pval,
                        input bit pp, input int pfl);
        bit exp_ready;
        bit qacc;
        push_valid = pv; push_flow = 2'(pf); push_rank = pr; push_value = pval;
        pop = pp; pop_flow = 2'(pfl);
        #1;
        exp_ready = 0;
        if (pf < 3) exp_ready = (mcnt[pf] < 4) || (pp && pfl == pf);
        check("push_ready", 32'(push_ready), 32'(exp_ready));
        if (pv && exp_ready) begin
            mlist[pf][mcnt[pf]] = {pr, pval};
            mcnt[pf]++;
        end
        qacc = 0;
        if (pp && pfl < 3) qacc = (mcnt[pfl] > 0);
        if (qacc) begin
            {m_rank, m_val} = mlist[pfl][0];
            for (int i = 0; i < 5; i++) mlist[pfl][i] = mlist[pfl][i+1];
            mcnt[pfl]--;
        end
        m_valid = qacc;
        if (pv && !exp_ready && pf < 3) m_ovf = 1;
        if (pp && !qacc && pfl < 3) m_unf = 1;
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic do_reset(input bit traffic);
        rst_n = 1'b0;
        push_valid = traffic; push_flow = 2'd1; push_rank = 8'h77; push_value = 8'h66;
        pop = traffic; pop_flow = 2'd0;
        @(posedge clk);
        #1;
        model_clear();
        rst_n = 1'b1; push_valid = 1'b0; pop = 1'b0;
        check_outputs();
    endtask

    task automatic idle();
        step(0, 0, 8'h00, 8'h00, 0, 0);
    endtask

    initial begin
        rst_n = 1'b0; push_valid = 1'b0; push_flow = '0; push_rank = '0; push_value = '0;
        pop = 1'b0; pop_flow = '0;
        model_clear();
        do_reset(0);

        // ranks 5,7,9 on flow 1, then drain
        step(1, 1, 8'd5, 8'h15, 0, 0);
        step(1, 1, 8'd7, 8'h17, 0, 0);
        step(1, 1, 8'd9, 8'h19, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 1);
        idle();

        // overflow flow 0 then drain
        for (int i = 0; i < 5; i++) step(1, 0, 8'(8'h10 + i), 8'(8'h20 + i), 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 0);

        // bypass on empty flow 2
        do_reset(0);
        step(1, 2, 8'h42, 8'h24, 1, 2);
        idle();

        // full flow 0 with same-cycle push+pop
        for (int i = 0; i < 4; i++) step(1, 0, 8'(8'h30 + i), 8'(8'h40 + i), 0, 0);
        step(1, 0, 8'hAA, 8'hBB, 1, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 0);

        // push/pop pairs on flow 1 across the wrap point, then underflow
        do_reset(0);
        step(1, 1, 8'h60, 8'h70, 0, 0);
        for (int i = 0; i < 6; i++) step(1, 1, 8'(8'h61 + i), 8'(8'h71 + i), 1, 1);
        step(0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 1, 1);

        // reset mid-traffic with counts 2,3,1
        do_reset(0);
        step(1, 0, 8'h01, 8'h01, 0, 0);
        step(1, 0, 8'h02, 8'h02, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 1, 8'(8'h03 + i), 8'h03, 0, 0);
        step(1, 2, 8'h06, 8'h06, 1, 3);
        do_reset(1);
        step(1, 1, 8'h99, 8'h98, 0, 0);
        step(1, 1, 8'h9A, 8'h97, 0, 0);
        step(0, 0, 0, 0, 1, 1);

        // randomized traffic with occasional resets
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset($urandom_range(0, 1) == 1);
            end else begin
                int pf;
                int pfl;
                pf  = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
                pfl = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
                step($urandom_range(0, 9) < 6, pf, 8'($urandom), 8'($urandom),
                     $urandom_range(0, 1) == 1, pfl);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/flow_rank_store.md
FLOW_RANK_STORE -- requirements
Module: flow_rank_store

Interface
REQ-001 SHALL have parameter DEPTH, default 16, entries per flow FIFO (>=2, power of two not required).
REQ-002 SHALL have parameter FLOWS, default 8, number of independent flows (>=2).
REQ-003 SHALL have parameter RANK_W, default 32, rank width in bits.
REQ-004 SHALL have parameter VALUE_W, default 32, value width in bits.
REQ-005 SHALL derive localparams FLOW_W = $clog2(FLOWS) and CNT_W = $clog2(DEPTH+1).
REQ-006 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst_n  in  1  reset, synchronous and active-low.
REQ-008 SHALL have port push_valid  in  1  enqueue request.
REQ-009 SHALL have port push_flow  in  FLOW_W  binary target flow of the push.
REQ-010 SHALL have port push_rank  in  RANK_W  rank stored with the entry.
REQ-011 SHALL have port push_value  in  VALUE_W  payload stored with the entry.
REQ-012 SHALL have port push_ready  out  1  push accepted this cycle when high together with push_valid.
REQ-013 SHALL have port pop  in  1  dequeue request.
REQ-014 SHALL have port pop_flow  in  FLOW_W  binary source flow of the pop.
REQ-015 SHALL have port pop_valid  out  1  registered; high one cycle after an accepted pop.
REQ-016 SHALL have port pop_rank  out  RANK_W  registered rank of the popped entry.
REQ-017 SHALL have port pop_value  out  VALUE_W  registered value of the popped entry.
REQ-018 SHALL have port head_valid  out  FLOWS  bit f high when flow f is non-empty.
REQ-019 SHALL have port head_rank  out  FLOWS*RANK_W  rank at head of each flow, slice f for flow f.
REQ-020 SHALL have port count  out  FLOWS*CNT_W  occupancy of each flow, slice f for flow f.
REQ-021 SHALL have port err_overflow  out  1  sticky: a push was dropped.
REQ-022 SHALL have port err_underflow  out  1  sticky: a pop found nothing.

Function
REQ-023 SHALL keep per flow a circular buffer of DEPTH entries with binary head/tail pointers wrapping DEPTH-1 -> 0 and a CNT_W-bit count.
REQ-024 SHALL drive push_ready combinationally = (push_flow < FLOWS) and (count[push_flow] < DEPTH or (pop and pop_flow == push_flow)).
REQ-025 SHALL write an accepted push at tail, advance tail, increment count, unless the same flow pops in the same cycle.
REQ-026 SHALL accept a pop when pop_flow < FLOWS and (count[pop_flow] > 0 or same-cycle accepted push to the same flow).
REQ-027 SHALL, on an accepted pop, register head entry into pop_rank/pop_value, advance head, decrement count; pop_valid = 1 next cycle.
REQ-028 SHALL, on same-flow push+pop with count 0, bypass: pop outputs the pushed rank/value next cycle, count stays 0, pointers unchanged.
REQ-029 SHALL, on same-flow push+pop with count > 0 (including DEPTH), perform both; count unchanged, both pointers advance.
REQ-030 SHALL process push and pop to different flows independently in the same cycle.
REQ-031 SHALL drop a push_valid with push_ready low (no state change) and set err_overflow if push_flow < FLOWS.
REQ-032 SHALL ignore a pop not accepted, drive pop_valid 0 next cycle, set err_underflow if pop_flow < FLOWS.
REQ-033 SHALL hold pop_rank/pop_value at their last values when no pop is accepted.
REQ-034 SHALL derive head_valid[f] = (count[f] != 0) and head_rank[f] from storage at head[f]; head_rank[f] is don't-care when head_valid[f] = 0.
REQ-035 SHALL keep err_overflow/err_underflow set until reset.

Reset
REQ-036 SHALL, with rst_n low at a clock edge, clear all pointers, counts, pop_valid, pop_rank, pop_value, err_overflow, err_underflow to 0; storage is not reset.
REQ-037 SHALL give reset priority over same-cycle push/pop; entries in flight are discarded and the first cycle after reset accepts pushes.

Verification (DEPTH=4, FLOWS=3, RANK_W=VALUE_W=8)
REQ-038 SHALL cover: push flow1 ranks 5,7,9 then 3 pops flow1 -> pop_valid each next cycle, pop_rank 5,7,9, count[1] 3->0, head_valid[1] 0.
REQ-039 SHALL cover: 4 pushes flow0 then 5th push no pop -> push_ready 0, err_overflow 1, count[0]=4; subsequent pops return first 4 values.
REQ-040 SHALL cover: empty flow2, same-cycle push rank 0x42 + pop flow2 -> next cycle pop_valid 1, pop_rank 0x42, count[2]=0, err_underflow 0.
REQ-041 SHALL cover: flow0 full, same-cycle push rank 0xAA + pop flow0 -> push_ready 1, oldest popped, count[0]=4, 0xAA later last out.
REQ-042 SHALL cover: 6 push/pop pairs on flow1 crossing wrap -> FIFO order preserved, head_rank[1] tracks head; pop on empty flow1 -> pop_valid 0, err_underflow 1.
REQ-043 SHALL cover: rst_n low mid-traffic with counts 2,3,1 -> all counts 0, flags 0, pop_valid 0; first push after reset returned first.
